fb_pixel_writer: RTL and testbench
==================================

Name: fb_pixel_writer

Overview:
- Write side of the 64x32 x 12-bit frame memory; the VGA scan-out path reads the same memory.
- Accepts pixel and fill commands over a valid/ready handshake and issues single-port write cycles (en/we/addr/din) to the memory's write port.
- Fill commands sweep a row, a column or the whole frame, one write per clock.
- Address mapping is fixed: addr = x + (y << 6), matching the scan-out side.

Parameters:
X_BITS, 6, horizontal cell index width (64 columns)
Y_BITS, 5, vertical cell index width (32 rows)
PIX_W, 12, pixel width {red[3:0], green[3:0], blue[3:0]}
ADDR_W, 11, memory address width (X_BITS + Y_BITS)

Ports:
clk_100MHz  in  1  system clock; sole clock of the block
reset_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present; must be held stable until accepted
cmd_ready  out  1  block can accept a command this cycle
cmd_op  in  2  00 = write pixel, 01 = fill row, 10 = fill column, 11 = clear frame
cmd_x  in  X_BITS  column; used by ops 00 and 10
cmd_y  in  Y_BITS  row; used by ops 00 and 01
cmd_color  in  PIX_W  colour written by every op
abort  in  1  synchronous; stops a running sweep
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_din  out  PIX_W  memory write data
busy  out  1  high while a command is executing
done  out  1  one-cycle pulse on the last write of a command

Behaviour:
- Reset: clk_100MHz is the only clock. reset_n is asynchronous and active-low. While reset_n is low: state=IDLE; mem_en=0, mem_we=0, mem_addr=0, mem_din=0, busy=0, done=0. cmd_ready=1 (IDLE).
- State machine: IDLE, WRITE, SWEEP.
- Handshake:
  - cmd_ready = (state==IDLE); it is a combinational decode of the state register only.
  - A command is accepted on a rising edge where cmd_valid && cmd_ready.
  - cmd_x, cmd_y, cmd_color and cmd_op are captured into registers at acceptance.
  - cmd_valid while busy is not accepted and causes no side effect.
- Outputs: mem_en=mem_we on every cycle; all memory outputs are registered.
- op 00 (write pixel): IDLE -> WRITE.
  - Cycle after acceptance: mem_we=1, addr = x + y*64, din = colour, done=1, busy=1.
  - Next cycle: back to IDLE, ready=1.
  - Throughput: 1 pixel per 2 cycles.
- op 01 (fill row): IDLE -> SWEEP. 64 consecutive write cycles, addr = y*64 + 0 .. y*64 + 63, ascending.
- op 10 (fill column): IDLE -> SWEEP. 32 consecutive write cycles, addr = x, x+64, ... x+31*64.
- op 11 (clear frame): IDLE -> SWEEP. 2048 consecutive write cycles, addr 0 .. 2047.
- Sweep timing:
  - First write occurs the cycle after acceptance.
  - done=1 on the final write cycle only; IDLE follows on the next cycle.
  - busy=1 from the cycle after acceptance through the final write, inclusive.
- Sweep counters:
  - x and y counters use exactly X_BITS and Y_BITS bits.
  - The end of a sweep is detected by comparing the counter with its all-ones value (63 or 31). It is never detected by overflow, so no wrap-around write to address 0 can occur.
- abort:
  - Sampled high in SWEEP: the write presented that cycle completes; the next state is IDLE; done is not asserted.
  - If abort coincides with the final write, done=1 (the command completed).
  - In IDLE or WRITE, abort is ignored.
- Reset mid-sweep: all outputs clear immediately and the sweep is discarded; no write follows reset release until a new command is accepted.
- Between writes and in IDLE: mem_addr and mem_din hold their last values and mem_we=0.

Decomposition:
- Shared package fb_pkg holds:
  - the constants X_BITS, Y_BITS, PIX_W, ADDR_W;
  - the op encodings OP_PIXEL, OP_ROW, OP_COL, OP_CLEAR;
  - the state encoding;
  - an address function addr = {y, x}.
- The VGA read path reuses fb_pkg.
- One natural sub-module, fb_sweep_counter: an x/y counter pair with per-axis enable and last flags. It drives the address in all three fill ops.

Test Plan:
- Reset release, then op 00, x=5, y=3, colour 0x0F0 -> one cycle with mem_we=1, addr=197, din=0x0F0, done=1; cmd_ready=0 for exactly one cycle.
- op 01, y=31, colour 0xF00 -> 64 back-to-back writes at addr 1984..2047; done coincides with addr 2047; no write to addr 0.
- op 10, x=63, colour 0x00F -> 32 writes at addr 63, 127, ... 2047; busy high for 32 cycles.
- op 11, colour 0xFFF -> 2048 writes covering every address once, in ascending order; a cmd_valid held during the sweep is accepted only on the cycle after done.
- op 11 with abort asserted on the cycle addr=100 is written -> writes stop after addr 100; done never pulses; IDLE and cmd_ready=1 on the next cycle.
- reset_n driven low mid-row-fill (asynchronous, between clock edges) -> mem_we=0 and busy=0 immediately; after release, no write until a new command is accepted.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared definitions for the 64x32 x 12-bit frame memory: geometry, command
// opcodes, writer state encoding and the fixed pixel address mapping.
package fb_pkg;

  localparam int X_BITS = 6;
  localparam int Y_BITS = 5;
  localparam int PIX_W  = 12;
  localparam int ADDR_W = X_BITS + Y_BITS;

  typedef enum logic [1:0] {
    OP_PIXEL = 2'b00,
    OP_ROW   = 2'b01,
    OP_COL   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_SWEEP = 2'd2
  } state_e;

  // addr = x + (y << 6), which is simply the concatenation {y, x}
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [X_BITS-1:0] x,
                                                input logic [Y_BITS-1:0] y);
    return {y, x};
  endfunction

  // A sweep has reached its final cell when the moving axis (or both axes
  // for a full clear) sits at its all-ones value.
  function automatic logic sweep_last(input op_e op, input logic x_last,
                                      input logic y_last);
    case (op)
      OP_ROW:  return x_last;
      OP_COL:  return y_last;
      default: return x_last & y_last;
    endcase
  endfunction

endpackage

// File: rtl/fb_sweep_counter.sv
// x/y cell counter pair for fill sweeps. Holds the cell currently being
// written; exposes the next cell combinationally so the writer can register
// the following address, plus all-ones flags used for end-of-sweep detection.
module fb_sweep_counter
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [X_BITS-1:0] i_x0,
  input  logic [Y_BITS-1:0] i_y0,
  input  logic              i_en_x,
  input  logic              i_en_y,
  output logic [X_BITS-1:0] o_x_nxt,
  output logic [Y_BITS-1:0] o_y_nxt,
  output logic              o_x_last,
  output logic              o_y_last
);

  logic [X_BITS-1:0] r_x;
  logic [Y_BITS-1:0] r_y;

  // Next cell: load has priority; each axis advances only when enabled and
  // wraps naturally within its own width (used by the frame clear on x).
  always_comb begin
    o_x_nxt = r_x;
    o_y_nxt = r_y;
    if (i_load) begin
      o_x_nxt = i_x0;
      o_y_nxt = i_y0;
    end else begin
      if (i_en_x) o_x_nxt = r_x + 1'b1;
      if (i_en_y) o_y_nxt = r_y + 1'b1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else begin
      r_x <= o_x_nxt;
      r_y <= o_y_nxt;
    end
  end

  assign o_x_last = &r_x;
  assign o_y_last = &r_y;

endmodule

// File: rtl/fb_pixel_writer.sv
// Write side of the frame memory. Accepts pixel/fill commands and issues one
// registered memory write per clock.
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
// cmd_ready is high only in IDLE and is decoded from the state register alone,
// so cmd_valid seen while busy has no effect and the producer simply holds it.
module fb_pixel_writer
  import fb_pkg::*;
(
  input  logic              clk_100MHz,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [X_BITS-1:0] cmd_x,
  input  logic [Y_BITS-1:0] cmd_y,
  input  logic [PIX_W-1:0]  cmd_color,
  input  logic              abort,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_din,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  state_e            r_state;
  state_e            w_state_nxt;
  op_e               r_op;
  op_e               w_op_nxt;
  op_e               w_cmd_op;

  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [PIX_W-1:0]  r_mem_din;
  logic              r_busy;
  logic              r_done;

  logic              w_we_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [PIX_W-1:0]  w_din_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;

  logic              w_load;
  logic [X_BITS-1:0] w_x0;
  logic [Y_BITS-1:0] w_y0;
  logic              w_en_x;
  logic              w_en_y;
  logic [X_BITS-1:0] w_x_nxt;
  logic [Y_BITS-1:0] w_y_nxt;
  logic              w_x_last;
  logic              w_y_last;
  logic              w_last;
  logic              w_nxt_last;

  assign w_cmd_op   = op_e'(cmd_op);
  assign cmd_ready  = (r_state == ST_IDLE);
  assign w_last     = sweep_last(r_op, w_x_last, w_y_last);
  assign w_nxt_last = sweep_last(r_op, &w_x_nxt, &w_y_nxt);

  fb_sweep_counter u_cnt (
    .clk      (clk_100MHz),
    .rst_n    (reset_n),
    .i_load   (w_load),
    .i_x0     (w_x0),
    .i_y0     (w_y0),
    .i_en_x   (w_en_x),
    .i_en_y   (w_en_y),
    .o_x_nxt  (w_x_nxt),
    .o_y_nxt  (w_y_nxt),
    .o_x_last (w_x_last),
    .o_y_last (w_y_last)
  );

  // Counter control: capture the start cell on acceptance (the pixel op loads
  // its own x/y too, so every first address comes from the counter), then
  // step the moving axis each sweep cycle. A clear steps y as x wraps.
  always_comb begin
    w_load = 1'b0;
    w_x0   = cmd_x;
    w_y0   = cmd_y;
    w_en_x = 1'b0;
    w_en_y = 1'b0;
    if (r_state == ST_IDLE) begin
      w_load = cmd_valid;
      case (w_cmd_op)
        OP_ROW:   w_x0 = '0;
        OP_COL:   w_y0 = '0;
        OP_CLEAR: begin
          w_x0 = '0;
          w_y0 = '0;
        end
        default:  ;
      endcase
    end else if (r_state == ST_SWEEP) begin
      case (r_op)
        OP_ROW:  w_en_x = 1'b1;
        OP_COL:  w_en_y = 1'b1;
        default: begin
          w_en_x = 1'b1;
          w_en_y = w_x_last;
        end
      endcase
    end
  end

  // Next-state and next registered outputs; address/data hold when idle.
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_mem_addr;
    w_din_nxt   = r_mem_din;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_op_nxt    = w_cmd_op;
          w_we_nxt    = 1'b1;
          w_addr_nxt  = fb_addr(w_x_nxt, w_y_nxt);
          w_din_nxt   = cmd_color;
          w_busy_nxt  = 1'b1;
          if (w_cmd_op == OP_PIXEL) begin
            w_state_nxt = ST_WRITE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_SWEEP;
          end
        end
      end
      ST_WRITE: w_state_nxt = ST_IDLE;
      ST_SWEEP: begin
        // The write on the bus now completes either way; abort or the final
        // cell ends the sweep (done was already raised with the final write).
        if (w_last || abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_we_nxt    = 1'b1;
          w_addr_nxt  = fb_addr(w_x_nxt, w_y_nxt);
          w_busy_nxt  = 1'b1;
          w_done_nxt  = w_nxt_last;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Registered command opcode and memory/status outputs
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_op       <= OP_PIXEL;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_op       <= w_op_nxt;
      r_mem_we   <= w_we_nxt;
      r_mem_addr <= w_addr_nxt;
      r_mem_din  <= w_din_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign mem_en    = r_mem_we;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_din   = r_mem_din;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Bench for fb_pixel_writer: directed and random commands, each expanded by
// a reference model into the list of addresses the frame should receive.
module tb_fb_pixel_writer;

  // ---------------- clock / reset ----------------
  logic        clk_100MHz = 1'b0;
  logic        reset_n    = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op    = '0;
  logic [5:0]  cmd_x     = '0;
  logic [4:0]  cmd_y     = '0;
  logic [11:0] cmd_color = '0;
  logic        abort     = 1'b0;
  logic        mem_en;
  logic        mem_we;
  logic [10:0] mem_addr;
  logic [11:0] mem_din;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  fb_pixel_writer dut (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .cmd_color  (cmd_color),
    .abort      (abort),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          vec = 0;
  int          err = 0;
  logic [10:0] last_addr = '0;
  logic [11:0] last_din  = '0;
  logic [10:0] exp_q[$];

  // Observed vector: {en, we, busy, done, ready, addr, din}
  task automatic check(input string tag, input logic [27:0] exp);
    logic [27:0] obs;
    obs = {mem_en, mem_we, busy, done, cmd_ready, mem_addr, mem_din};
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] idle_exp();
    return {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, last_addr, last_din};
  endfunction

  // Reference model: the cells a command touches, in write order
  task automatic build_model(input logic [1:0] op, input int x, input int y);
    exp_q.delete();
    case (op)
      2'd0: exp_q.push_back(11'(x + 64 * y));
      2'd1: for (int i = 0; i < 64; i++) exp_q.push_back(11'(y * 64 + i));
      2'd2: for (int i = 0; i < 32; i++) exp_q.push_back(11'(x + 64 * i));
      default: for (int i = 0; i < 2048; i++) exp_q.push_back(11'(i));
    endcase
  endtask

  // ---------------- driver ----------------
  // ab: index of the write during which abort is raised (-1: none).
  // chain: keep cmd_valid high after acceptance, presenting the next command.
  logic [1:0]  ch_op;
  logic [5:0]  ch_x;
  logic [4:0]  ch_y;
  logic [11:0] ch_color;

  task automatic issue(input logic [1:0] op, input logic [5:0] x,
                       input logic [4:0] y, input logic [11:0] col,
                       input int ab, input bit chain);
    int n;
    int stop;
    logic [10:0] a;
    @(negedge clk_100MHz);
    cmd_op = op; cmd_x = x; cmd_y = y; cmd_color = col; cmd_valid = 1'b1;
    check($sformatf("idle_before_op%0d", op), idle_exp());
    build_model(op, int'(x), int'(y));
    n    = exp_q.size();
    stop = (ab >= 0 && ab < n) ? ab : n - 1;
    @(posedge clk_100MHz);
    #1;
    if (chain) begin
      cmd_op = ch_op; cmd_x = ch_x; cmd_y = ch_y; cmd_color = ch_color;
    end else begin
      cmd_valid = 1'b0;
    end
    for (int i = 0; i <= stop; i++) begin
      @(negedge clk_100MHz);
      a = exp_q[i];
      check($sformatf("write_op%0d_i%0d", op, i),
            {1'b1, 1'b1, 1'b1, (i == n - 1), 1'b0, a, col});
      if (i == ab) begin
        abort = 1'b1;
        @(posedge clk_100MHz);
        #1 abort = 1'b0;
      end
    end
    last_addr = exp_q[stop];
    last_din  = col;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ab;
    logic [1:0] rop;
    #3;
    check("reset_state", {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'd0, 12'd0});
    vec++;
    assert (dbg_state === 2'd0) else begin
      err++;
      $error("FAIL reset_dbg_state observed=%0d expected=0", dbg_state);
    end
    #10 reset_n = 1'b1;

    // single pixel: addr 5 + 3*64 = 197
    issue(2'd0, 6'd5, 5'd3, 12'h0F0, -1, 1'b0);
    // last row, ends exactly at 2047
    issue(2'd1, 6'd0, 5'd31, 12'hF00, -1, 1'b0);
    // last column
    issue(2'd2, 6'd63, 5'd0, 12'h00F, -1, 1'b0);
    // full clear with the next command held valid throughout
    ch_op = 2'd0; ch_x = 6'd1; ch_y = 5'd2; ch_color = 12'hABC;
    issue(2'd3, 6'd0, 5'd0, 12'hFFF, -1, 1'b1);
    issue(2'd0, 6'd1, 5'd2, 12'hABC, -1, 1'b0);
    // clear aborted while addr 100 is written
    issue(2'd3, 6'd0, 5'd0, 12'h123, 100, 1'b0);
    // abort on the final write of a column still completes with done
    issue(2'd2, 6'd9, 5'd0, 12'h456, 31, 1'b0);

    // random pixel / row / column commands with occasional aborts
    for (int k = 0; k < 24; k++) begin
      rop = 2'($urandom_range(0, 2));
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 70)) : -1;
      issue(rop, 6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)),
            12'($urandom), ab, 1'b0);
    end

    // asynchronous reset in the middle of a row fill
    @(negedge clk_100MHz);
    cmd_op = 2'd1; cmd_x = 6'd0; cmd_y = 5'd7; cmd_color = 12'h5A5; cmd_valid = 1'b1;
    check("idle_before_rst_row", idle_exp());
    @(posedge clk_100MHz);
    #1 cmd_valid = 1'b0;
    repeat (10) @(posedge clk_100MHz);
    #2 reset_n = 1'b0;
    #1 check("async_reset_clear", {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'd0, 12'd0});
    @(negedge clk_100MHz);
    #2 reset_n = 1'b1;
    last_addr = '0;
    last_din  = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_100MHz);
      check($sformatf("post_reset_idle_%0d", i), idle_exp());
    end
    issue(2'd0, 6'd63, 5'd31, 12'h321, -1, 1'b0);
    @(negedge clk_100MHz);
    check("final_idle", idle_exp());

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
